// File: rtl/i2c_pkg.sv
// Shared definitions for the ADT7420 I2C temperature reader.
//   i2c_state_t    : transaction FSM states
//   ADT7420_ADDR   : default 7-bit sensor address
//   PHASES_PER_BIT : quarter ticks per SCL bit time
//   BIT_IDX_W      : width of the in-byte bit counter
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_SACK,
        ST_RD_HI,
        ST_MACK,
        ST_RD_LO,
        ST_MNACK,
        ST_STOP
    } i2c_state_t;

    localparam logic [6:0]  ADT7420_ADDR   = 7'h4B;
    localparam int unsigned PHASES_PER_BIT = 4;
    localparam int unsigned BIT_IDX_W      = 3;

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-bit tick generator: divides clk by QTR and counts bit phases.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the divider and phase count at 0
//   en         : count while high
//   tick_c     : one-cycle strobe on the last clock of each quarter period
//   phase      : 2-bit phase within the current bit (advances after each tick)
module i2c_qtr_tick #(
    parameter int unsigned QTR = 62
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic       tick_c,
    output logic [1:0] phase
);

    localparam int unsigned    CNT_W   = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QTR - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && (cnt == CNT_MAX);

    // Divider and phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= '0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= '0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adt7420_i2c_rd.sv
// I2C master that reads the 16-bit TEMP register of an ADT7420.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle read request (ignored while busy)
//   busy       : transaction in progress
//   temp_data  : last good TEMP word {MSB, LSB}
//   temp_valid : one-cycle strobe, temp_data updated in the same cycle
//   ack_err    : one-cycle strobe, address not acknowledged
//   scl        : push-pull I2C clock
//   sda        : open-drain I2C data (0 or released)
// SCL/SDA are registered from the current state/phase, so the pins trail the
// FSM by one clock; all pin timing relations are preserved by that shift.
module adt7420_i2c_rd
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCL_HZ   = 400_000,
    parameter logic [6:0]  I2C_ADDR = ADT7420_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        ack_err,
    output logic        scl,
    inout  logic        sda
);

    // QTR must come out >= 2 for the chosen clock/SCL ratio.
    localparam int unsigned QTR = CLK_HZ / (4 * SCL_HZ);

    localparam logic [1:0]           PH_LAST   = 2'(PHASES_PER_BIT - 1);
    localparam logic [1:0]           PH_SAMPLE = 2'(PHASES_PER_BIT - 2);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST  = '1;
    localparam logic [7:0]           ADDR_RD   = {I2C_ADDR, 1'b1};

    i2c_state_t           state, state_n;
    logic [BIT_IDX_W-1:0] bit_cnt, bit_cnt_n;
    logic [15:0]          shreg, shreg_n;
    logic                 nack, nack_n;
    logic                 busy_n, temp_valid_n, ack_err_n, scl_n, sda_low_n;
    logic [15:0]          temp_data_n;
    logic                 sda_low;
    logic                 sda_in;
    logic                 tick_c;
    logic [1:0]           phase;
    logic                 start_acc_c;
    logic                 sample_c;
    logic                 bit_end_c;

    assign sda    = sda_low ? 1'b0 : 'z;
    assign sda_in = sda;

    assign start_acc_c = (state == ST_IDLE) && start;
    assign sample_c    = tick_c && (phase == PH_SAMPLE);
    assign bit_end_c   = tick_c && (phase == PH_LAST);

    i2c_qtr_tick #(.QTR(QTR)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_acc_c),
        .en     (state != ST_IDLE),
        .tick_c (tick_c),
        .phase  (phase)
    );

    // Next-state, datapath and pin decode.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        nack_n       = nack;
        temp_data_n  = temp_data;
        temp_valid_n = 1'b0;
        ack_err_n    = 1'b0;
        scl_n        = 1'b1;
        sda_low_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_START;
                    bit_cnt_n = '0;
                    nack_n    = 1'b0;
                end
            end
            ST_START: begin
                // Bus-free half, then SDA falls with SCL still high.
                sda_low_n = phase[1];
                if (bit_end_c) state_n = ST_ADDR;
            end
            ST_ADDR: begin
                scl_n     = phase[1];
                sda_low_n = ~ADDR_RD[BIT_LAST - bit_cnt];
                if (bit_end_c) begin
                    bit_cnt_n = bit_cnt + BIT_IDX_W'(1);
                    if (bit_cnt == BIT_LAST) state_n = ST_SACK;
                end
            end
            ST_SACK: begin
                scl_n = phase[1];
                if (sample_c && sda_in) begin
                    nack_n    = 1'b1;
                    ack_err_n = 1'b1;
                end
                if (bit_end_c) state_n = nack ? ST_STOP : ST_RD_HI;
            end
            ST_RD_HI, ST_RD_LO: begin
                scl_n = phase[1];
                if (sample_c) shreg_n = {shreg[14:0], sda_in};
                if (bit_end_c) begin
                    bit_cnt_n = bit_cnt + BIT_IDX_W'(1);
                    if (bit_cnt == BIT_LAST)
                        state_n = (state == ST_RD_HI) ? ST_MACK : ST_MNACK;
                end
            end
            ST_MACK: begin
                scl_n     = phase[1];
                sda_low_n = 1'b1;
                if (bit_end_c) state_n = ST_RD_LO;
            end
            ST_MNACK: begin
                scl_n = phase[1];
                if (bit_end_c) state_n = ST_STOP;
            end
            ST_STOP: begin
                // SDA held low through SCL rise, released in the last quarter.
                scl_n     = phase[1];
                sda_low_n = (phase != PH_LAST);
                if (bit_end_c) begin
                    state_n = ST_IDLE;
                    if (!nack) begin
                        temp_data_n  = shreg;
                        temp_valid_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            nack       <= 1'b0;
            busy       <= 1'b0;
            temp_data  <= '0;
            temp_valid <= 1'b0;
            ack_err    <= 1'b0;
            scl        <= 1'b1;
            sda_low    <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            nack       <= nack_n;
            busy       <= busy_n;
            temp_data  <= temp_data_n;
            temp_valid <= temp_valid_n;
            ack_err    <= ack_err_n;
            scl        <= scl_n;
            sda_low    <= sda_low_n;
        end
    end

endmodule

// File: tb/tb_adt7420_i2c_rd.sv
// Bench for adt7420_i2c_rd: ADT7420 bus model, SCL/SDA protocol monitor and
// directed read scenarios.
module tb_adt7420_i2c_rd;

    localparam int QTR      = 100_000_000 / (4 * 400_000);  // 62
    localparam int LAT_OK   = 116 * QTR + 1;                // 7193
    localparam int LAT_NACK = 39 * QTR + 1;                 // 2419
    localparam int LAT_NDONE = 44 * QTR + 1;                // 2729

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic [15:0] temp_data;
    logic        temp_valid;
    logic        ack_err;
    logic        scl;
    wire         sda;

    int checks = 0;
    int failures = 0;

    pullup (sda);

    always #5 clk = ~clk;

    adt7420_i2c_rd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .ack_err    (ack_err),
        .scl        (scl),
        .sda        (sda)
    );

    // ---------------- ADT7420 model ----------------
    logic        m_present = 1'b1;
    logic [15:0] m_temp = 16'h0000;
    logic        m_low = 1'b0;
    logic        m_sel = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic        m_scl_q = 1'b1;
    logic        m_sda_q = 1'b1;
    int          m_f = 99;

    assign sda = (m_low && rst_n) ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_low = 1'b0; m_sel = 1'b0; m_f = 99;
        end else begin
            if (scl && m_scl_q && m_sda_q && !sda) begin
                m_f = 0; m_addr = 8'h00; m_sel = 1'b0;
            end else if (!scl && m_scl_q) begin
                m_f++;
                m_low = 1'b0;
                if (m_f == 9) begin
                    m_sel = m_present && (m_addr == {7'h4B, 1'b1});
                    m_low = m_sel;
                end else if (m_f >= 10 && m_f <= 17) begin
                    m_low = m_sel && !m_temp[25 - m_f];
                end else if (m_f >= 19 && m_f <= 26) begin
                    m_low = m_sel && !m_temp[26 - m_f];
                end
            end else if (scl && !m_scl_q && m_f >= 1 && m_f <= 8) begin
                m_addr = {m_addr[6:0], sda};
            end
        end
        m_scl_q = scl;
        m_sda_q = sda;
    end

    // ---------------- protocol monitor ----------------
    logic p_scl_q = 1'b1;
    logic p_sda_q = 1'b1;
    logic p_busy_q = 1'b0;
    logic hi_ok = 1'b0;
    logic lo_ok = 1'b0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    int   evt = 0;
    int   viol = 0;
    int   per_cnt = 0;
    int   stop_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_ok = 1'b0; lo_ok = 1'b0; hi_cnt = 0; lo_cnt = 0; evt = 0;
        end else begin
            if (busy && !p_busy_q) begin
                evt = 0; hi_ok = 1'b0;
            end
            if (scl && p_scl_q && sda !== p_sda_q) begin
                evt++;
                if (sda === 1'b1) stop_cnt++;
                if (!busy) viol++;
                else if (evt == 1 && sda !== 1'b0) viol++;
                else if (evt == 2 && sda !== 1'b1) viol++;
                else if (evt > 2) viol++;
            end
            if (!busy && p_busy_q && evt != 2) viol++;
            if (!scl && p_scl_q) begin
                if (hi_ok) begin per_cnt++; if (hi_cnt != 2 * QTR) viol++; end
                hi_ok = 1'b0; lo_ok = 1'b1; lo_cnt = 1;
            end else if (scl && !p_scl_q) begin
                if (lo_ok) begin per_cnt++; if (lo_cnt != 2 * QTR) viol++; end
                lo_ok = 1'b0; hi_ok = 1'b1; hi_cnt = 1;
            end else if (scl) begin
                hi_cnt++;
            end else begin
                lo_cnt++;
            end
        end
        p_scl_q  = scl;
        p_sda_q  = sda;
        p_busy_q = busy;
    end

    // One read: optionally raise start, then follow until busy falls.
    task automatic do_read(input bit pre, input int extra_at, input bit chain,
                           output int lat_v, output int lat_e, output int lat_d,
                           output int nv, output int ne, output bit tmo);
        lat_v = -1; lat_e = -1; lat_d = -1; nv = 0; ne = 0; tmo = 1'b1;
        if (!pre) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int k = 1; k <= 10000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == extra_at) start = 1'b1;
            if (temp_valid) begin nv++; if (lat_v < 0) lat_v = k; end
            if (ack_err) begin ne++; if (lat_e < 0) lat_e = k; end
            if (!busy && k > 1) begin
                lat_d = k; tmo = 1'b0;
                if (chain) start = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (scl !== 1'b1) begin failures++; $display("FAIL reset_scl got %b exp 1", scl); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got %b exp 1 (released)", sda); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (temp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", temp_valid); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL reset_ack_err got %b exp 0", ack_err); end
        checks++; if (temp_data !== 16'h0000) begin failures++; $display("FAIL reset_data got %h exp 0000", temp_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic_read();
        int lv, le, ld, nv, ne, v0, p0, s0;
        bit tmo;
        m_present = 1'b1; m_temp = 16'h0C80;
        v0 = viol; p0 = per_cnt; s0 = stop_cnt;
        do_read(1'b0, 0, 1'b0, lv, le, ld, nv, ne, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL basic_timeout got busy stuck exp done"); end
        checks++; if (lv != LAT_OK) begin failures++; $display("FAIL basic_latency got %0d exp %0d", lv, LAT_OK); end
        checks++; if (ld != LAT_OK) begin failures++; $display("FAIL basic_busy_fall got %0d exp %0d", ld, LAT_OK); end
        checks++; if (nv != 1) begin failures++; $display("FAIL basic_valid_count got %0d exp 1", nv); end
        checks++; if (ne != 0) begin failures++; $display("FAIL basic_ack_err got %0d exp 0", ne); end
        checks++; if (temp_data !== 16'h0C80) begin failures++; $display("FAIL basic_data got %h exp 0c80", temp_data); end
        checks++; if (viol - v0 != 0) begin failures++; $display("FAIL basic_protocol got %0d violations exp 0", viol - v0); end
        checks++; if (per_cnt - p0 != 55) begin failures++; $display("FAIL basic_scl_periods got %0d exp 55", per_cnt - p0); end
        checks++; if (stop_cnt - s0 != 1) begin failures++; $display("FAIL basic_stop got %0d exp 1", stop_cnt - s0); end
    endtask

    task automatic test_data_patterns();
        int lv, le, ld, nv, ne, v0;
        bit tmo;
        logic [15:0] pat [2];
        pat[0] = 16'hFFFF; pat[1] = 16'h0000;
        v0 = viol;
        for (int i = 0; i < 2; i++) begin
            m_temp = pat[i];
            do_read(1'b0, 0, 1'b0, lv, le, ld, nv, ne, tmo);
            checks++; if (tmo || nv != 1) begin failures++; $display("FAIL pattern%0d_valid got %0d exp 1", i, nv); end
            checks++; if (temp_data !== pat[i]) begin failures++; $display("FAIL pattern%0d_data got %h exp %h", i, temp_data, pat[i]); end
        end
        checks++; if (viol - v0 != 0) begin failures++; $display("FAIL pattern_protocol got %0d exp 0", viol - v0); end
    endtask

    task automatic test_nack();
        int lv, le, ld, nv, ne, v0, p0, s0;
        bit tmo;
        m_present = 1'b0; m_temp = 16'h1234;
        v0 = viol; p0 = per_cnt; s0 = stop_cnt;
        do_read(1'b0, 0, 1'b0, lv, le, ld, nv, ne, tmo);
        checks++; if (tmo) begin failures++; $display("FAIL nack_timeout got busy stuck exp done"); end
        checks++; if (ne != 1) begin failures++; $display("FAIL nack_ack_err_count got %0d exp 1", ne); end
        checks++; if (le != LAT_NACK) begin failures++; $display("FAIL nack_ack_err_time got %0d exp %0d", le, LAT_NACK); end
        checks++; if (ld != LAT_NDONE) begin failures++; $display("FAIL nack_busy_fall got %0d exp %0d", ld, LAT_NDONE); end
        checks++; if (nv != 0) begin failures++; $display("FAIL nack_valid got %0d exp 0", nv); end
        checks++; if (temp_data !== 16'h0000) begin failures++; $display("FAIL nack_data_held got %h exp 0000", temp_data); end
        checks++; if (stop_cnt - s0 != 1) begin failures++; $display("FAIL nack_stop got %0d exp 1", stop_cnt - s0); end
        checks++; if (per_cnt - p0 != 19) begin failures++; $display("FAIL nack_scl_periods got %0d exp 19", per_cnt - p0); end
        checks++; if (viol - v0 != 0) begin failures++; $display("FAIL nack_protocol got %0d exp 0", viol - v0); end
        m_present = 1'b1;
    endtask

    task automatic test_start_while_busy();
        int lv, le, ld, nv, ne;
        bit tmo;
        m_temp = 16'h1234;
        do_read(1'b0, 100, 1'b0, lv, le, ld, nv, ne, tmo);
        checks++; if (tmo || nv != 1) begin failures++; $display("FAIL busy_start_valid got %0d exp 1", nv); end
        checks++; if (temp_data !== 16'h1234) begin failures++; $display("FAIL busy_start_data got %h exp 1234", temp_data); end
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_queued got busy=%b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lv, le, ld, nv, ne, v0;
        bit tmo;
        v0 = viol;
        m_temp = 16'hABCD;
        do_read(1'b0, 0, 1'b1, lv, le, ld, nv, ne, tmo);
        checks++; if (temp_data !== 16'hABCD) begin failures++; $display("FAIL b2b_first_data got %h exp abcd", temp_data); end
        m_temp = 16'h5A5A;
        do_read(1'b1, 0, 1'b0, lv, le, ld, nv, ne, tmo);
        checks++; if (lv != LAT_OK) begin failures++; $display("FAIL b2b_second_latency got %0d exp %0d", lv, LAT_OK); end
        checks++; if (temp_data !== 16'h5A5A) begin failures++; $display("FAIL b2b_second_data got %h exp 5a5a", temp_data); end
        checks++; if (viol - v0 != 0) begin failures++; $display("FAIL b2b_protocol got %0d exp 0", viol - v0); end
    endtask

    task automatic test_reset_mid();
        int lv, le, ld, nv, ne, v0;
        bit tmo;
        m_temp = 16'h0C80;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2700) @(negedge clk);   // inside the MSB data byte
        #2 rst_n = 1'b0;
        #1;
        checks++; if (scl !== 1'b1) begin failures++; $display("FAIL midrst_scl got %b exp 1", scl); end
        checks++; if (sda !== 1'b1) begin failures++; $display("FAIL midrst_sda got %b exp 1 (released)", sda); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b exp 0", busy); end
        checks++; if (temp_data !== 16'h0000) begin failures++; $display("FAIL midrst_data got %h exp 0000", temp_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        v0 = viol;
        do_read(1'b0, 0, 1'b0, lv, le, ld, nv, ne, tmo);
        checks++; if (lv != LAT_OK) begin failures++; $display("FAIL midrst_latency got %0d exp %0d", lv, LAT_OK); end
        checks++; if (temp_data !== 16'h0C80) begin failures++; $display("FAIL midrst_reread got %h exp 0c80", temp_data); end
        checks++; if (viol - v0 != 0) begin failures++; $display("FAIL midrst_protocol got %0d exp 0", viol - v0); end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_data_patterns();
        test_nack();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adt7420_i2c_rd.md
# adt7420_i2c_rd

Synthesizable I2C master that reads the 16-bit TEMP register of an ADT7420 temperature sensor. It issues one read transaction per `start` pulse and drives SCL push-pull. SDA is open-drain, with a board pull-up. The block presents the captured word with a one-cycle valid strobe. It sits between the on-board sensor (pins `scl`/`sda`) and the temperature conversion/display logic.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SCL_HZ`, 400_000, target SCL frequency; quarter-period `QTR = CLK_HZ/(4*SCL_HZ)` (integer truncation, must be ≥ 2; default 62).
- `I2C_ADDR`, 7'h4B, 7-bit slave address.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 system clock
- `rst_n` in 1 asynchronous active-low reset
- `start` in 1 one-cycle request to begin a read; ignored while `busy`
- `busy` out 1 high from accepted `start` until STOP completes
- `temp_data` out 16 last successfully read TEMP word {MSB, LSB}
- `temp_valid` out 1 one-cycle strobe; `temp_data` updated in the same cycle
- `ack_err` out 1 one-cycle strobe; slave did not ACK the address
- `scl` out 1 I2C clock, push-pull
- `sda` inout 1 open-drain: driven 0 or 'z, never 1

## Operation
- Bit time = 4 quarter ticks: phases 0–1 SCL low, phases 2–3 SCL high.
- SDA changes only at the start of phase 0. SDA is sampled at the start of phase 3.
- States: IDLE → START → ADDR → SACK → RD_HI → MACK → RD_LO → MNACK → STOP → IDLE.
- IDLE: SCL=1, SDA released. On `start`, go to START; `busy` rises the next cycle.
- START: SDA pulled low for 2 ticks with SCL high, then SCL falls.
- ADDR: 8 bits MSB first, `{I2C_ADDR, 1'b1}`. A transmitted 1 means SDA is released.
- SACK: SDA released; sample. If the sample is 0, go to RD_HI. If the sample is 1, pulse `ack_err` and go to STOP, with no `temp_valid`.
- RD_HI / RD_LO: SDA released; shift in 8 bits MSB first into a 16-bit shift register.
- MACK: SDA driven low for one bit time.
- MNACK: SDA released for one bit time.
- STOP: SCL low with SDA low for 2 ticks, then SCL high for 1 tick, then SDA released for 1 tick. Then go to IDLE.
- Successful completion: on entry to IDLE after a successful read, `temp_data` ← shift register and `temp_valid`=1 for one cycle; `busy` falls in the same cycle.
- After `ack_err`: `temp_data` holds its previous value.
- `start` while busy: dropped, not queued. `start` in the same cycle `busy` falls is accepted.

## Timing
- Reset values: `scl`=1, `sda`='z, `temp_data`=16'h0000, `temp_valid`=0, `ack_err`=0, `busy`=0, tick counter=0, state=IDLE.
- Reset mid-transaction: outputs return to reset values asynchronously. No STOP is generated; the slave resynchronizes on the next START.
- Tick counter: counts 0..QTR-1 only while not IDLE; it is cleared on entry to START.
- Successful read: START 4 + 27 bits × 4 + STOP 4 = 116 ticks. `temp_valid` is asserted 116×QTR+1 clocks after the `start` cycle (default 7193 clocks).
- Address NACK: `ack_err` pulses at the SACK sample tick. `busy` falls after STOP, (4+9×4+4)×QTR+1 clocks after `start`.
- SCL high and low times are each exactly 2×QTR clocks. SDA never changes while SCL is high, except in START and STOP.

## Structure
- Shared package `i2c_pkg`:
  - state enum `i2c_state_t`
  - `ADT7420_ADDR` = 7'h4B
  - `PHASES_PER_BIT` = 4
  - bit-index width constant
- Sub-module `i2c_qtr_tick`: parameterized by `QTR`. Inputs: clear and enable. Outputs: a `tick` strobe and a 2-bit phase count.
- FSM, bit counter (0..7) and shift register live in `adt7420_i2c_rd`.
- SDA tristate is a single continuous assign in the top module: `sda = sda_low ? 1'b0 : 'z`.

## Test plan
- Sensor model at 0x4B with temp=16'h0C80, pull-up on `sda`, one `start` → `temp_valid` once after 7193 clocks, `temp_data`=16'h0C80, `ack_err` never asserts.
- temp=16'hFFFF then 16'h0000, two sequential reads → `temp_data` = FFFF then 0000. This covers all-released and all-driven data bits.
- No slave on the bus (pull-up only), `start` → `ack_err` pulse, no `temp_valid`, `temp_data` unchanged, STOP seen (SDA rises while SCL=1).
- `start` pulsed 100 cycles into a transaction → ignored; exactly one `temp_valid`. `start` in the same cycle `busy` falls → second read runs.
- Assert `rst_n`=0 mid-RD_HI → `scl`=1, `sda`='z, `busy`=0 immediately. After release, a new read returns the correct value.
- Protocol checker throughout: SDA is stable while SCL is high, except START and STOP. SCL high and low periods are each 2×QTR clocks.
